norm_sched: RTL
===============

Name: norm_sched

Overview:
- Scheduler that shares one N(x) CDF engine (Q16.16, start/done handshake, alternates d1 then d2 per start) between NREQ requesters.
- Each requester submits a (d1, d2) pair. The block arbitrates round-robin and drives two engine runs per job.
- It returns N(d1) and N(d2) with the requester ID.
- It sits between the per-option pricing lanes and the shared norm engine in the Black-Scholes calculator.

Parameters:
- WIDTH, 32, data width (Q16.16 signed).
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester ID width.
- TIMEOUT, 64, max cycles to wait for each engine completion.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_d1  in  NREQ*WIDTH  flattened d1, requester i at [i*WIDTH +: WIDTH].
- req_d2  in  NREQ*WIDTH  flattened d2, same layout.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of response.
- rsp_nd1  out  WIDTH  N(d1), Q16.16.
- rsp_nd2  out  WIDTH  N(d2), Q16.16.
- rsp_err  out  1  response aborted by timeout.
- eng_start  out  1  engine start level.
- eng_d1  out  WIDTH  engine d1 operand.
- eng_d2  out  WIDTH  engine d2 operand.
- eng_reset  out  1  engine reset pulse (phase resync).
- eng_done  in  1  engine done level.
- eng_nd1  in  WIDTH  engine N(d1) output.
- eng_nd2  in  WIDTH  engine N(d2) output.
- busy  out  1  job in flight (state != IDLE).
- timeout_err  out  1  sticky; set on any timeout.

Behaviour:
- One clock; reset is synchronous and active-high, on clk/reset as named.
- Reset values: all outputs 0; state IDLE; round-robin pointer rr=0.
- States and transitions:
  - IDLE: if any req_valid, grant the first valid index at or after rr (wrapping). Assert req_ready[g] for exactly that cycle. Latch d1/d2 into eng_d1/eng_d2 and g into rsp_id. Set rr=(g+1) mod NREQ. Go to ISSUE1. No req_valid -> stay.
  - ISSUE1: hold eng_start=1 for exactly 2 cycles, covering the engine leaving its hold state and then latching. Then eng_start=0, clear the timeout counter, go to WAIT1.
  - WAIT1: on eng_done rising edge (registered previous value 0, current 1), capture eng_nd1 into rsp_nd1 and go to ISSUE2.
  - ISSUE2 / WAIT2: same as ISSUE1/WAIT1. On rising edge, capture eng_nd2 into rsp_nd2 and go to RESP.
  - RESP: rsp_valid=1, outputs stable until rsp_ready=1. Then rsp_valid=0 next cycle and return to IDLE.
- eng_d1/eng_d2 are held constant from grant until RESP exits.
- Timeout: counter increments each WAIT cycle. When it reaches TIMEOUT-1 without a rising edge:
  - set timeout_err and rsp_err;
  - zero rsp_nd1/rsp_nd2;
  - pulse eng_reset for 1 cycle so the engine's d1/d2 phase resyncs;
  - go to RESP.
- rsp_err clears on the next grant. timeout_err clears only on reset.
- Engine phase invariant: runs are always issued in pairs. A job never leaves without two completions or a timeout-plus-eng_reset.
- Arithmetic: rr wraps modulo NREQ. The timeout counter is $clog2(TIMEOUT+1) bits and saturates. No data arithmetic; values pass through unmodified.
- Simultaneous requests: only one grant per IDLE cycle. Losers hold req_valid (their data must be stable) until granted.
- req_valid dropping before grant is allowed (no grant is issued).
- Reset mid-job discards the job with no response. The engine is reset on the same reset net by integration.
- Throughput: one job per (2 engine runs + 4 issue cycles + ~3) cycles. No request is accepted during a job.

Decomposition:
- Shared package bs_pkg holds:
  - state enum norm_sched_state_t (IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP);
  - Q16.16 constants ONE=32'h00010000 and HALF;
  - default TIMEOUT.
- One sub-module is natural: rr_arbiter (NREQ-wide round-robin, inputs req/rr, outputs grant one-hot + index). Reusable by other shared datapath units, e.g. the exp engine.

Test Plan:
- Single request, req 2, d1=0x00010000, d2=0 -> rsp_id=2, rsp_nd1≈0x0000D754 (0.8413), rsp_nd2≈0x00008000 ±0x40, rsp_err=0, eng_start high 2 cycles per run.
- All 4 valid simultaneously, pairs (0,0) -> grants in order 0,1,2,3. Then with rr=0, requests 1 and 3 -> grant 1 then 3.
- Negative input d1=0xFFFF0000, d2=0xFFFE0000 -> rsp_nd1≈0x000028AC (0.1587), rsp_nd2≈0x000005D4 (0.0228), confirming correct pair phase over 5 back-to-back jobs.
- rsp_ready held low 10 cycles in RESP -> rsp_valid, rsp_nd1/nd2, rsp_id stable; no new req_ready until handshake.
- Engine model never asserts eng_done -> after TIMEOUT cycles, rsp_err=1, nd outputs 0, timeout_err=1 sticky, eng_reset one-cycle pulse; next job completes normally with rsp_err=0.
- Synchronous reset asserted during WAIT2 -> next cycle all outputs 0, state IDLE, no response emitted, rr=0.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared definitions for the Black-Scholes datapath: scheduler states,
// Q16.16 constants and the default engine completion timeout.
package bs_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        RESP   = 3'd5
    } norm_sched_state_t;

    localparam logic signed [31:0] ONE  = 32'h0001_0000;
    localparam logic signed [31:0] HALF = 32'h0000_8000;

    localparam int NORM_TIMEOUT = 64;

endpackage

// File: rtl/norm_sched_if.sv
// Request, response and engine signals between the pricing lanes, the
// norm scheduler and the shared N(x) engine.
interface norm_sched_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) ();

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_d1;
    logic [NREQ*WIDTH-1:0]   req_d2;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic signed [WIDTH-1:0] rsp_nd1;
    logic signed [WIDTH-1:0] rsp_nd2;
    logic                    rsp_err;

    logic                    eng_start;
    logic signed [WIDTH-1:0] eng_d1;
    logic signed [WIDTH-1:0] eng_d2;
    logic                    eng_reset;
    logic                    eng_done;
    logic signed [WIDTH-1:0] eng_nd1;
    logic signed [WIDTH-1:0] eng_nd2;

    // Scheduler side.
    modport slave (
        input  req_valid, req_d1, req_d2, rsp_ready, eng_done, eng_nd1, eng_nd2,
        output req_ready, rsp_valid, rsp_id, rsp_nd1, rsp_nd2, rsp_err,
               eng_start, eng_d1, eng_d2, eng_reset
    );

    // Requester / consumer / engine side.
    modport master (
        output req_valid, req_d1, req_d2, rsp_ready, eng_done, eng_nd1, eng_nd2,
        input  req_ready, rsp_valid, rsp_id, rsp_nd1, rsp_nd2, rsp_err,
               eng_start, eng_d1, eng_d2, eng_reset
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, wrapping, and returns it both one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_i) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/norm_sched.sv
// Shares one N(x) engine between NREQ pricing lanes: grants a (d1, d2) job,
// runs the engine twice (d1 then d2) and returns both results with the ID.
module norm_sched
    import bs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = NORM_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    norm_sched_if.slave   bus,
    output logic          busy,
    output logic          timeout_err
);

    localparam int TCW = $clog2(TIMEOUT + 1);

    norm_sched_state_t       state_q;
    logic [IDW-1:0]          rr_q;
    logic [IDW-1:0]          rsp_id_q;
    logic                    icnt_q;
    logic [TCW-1:0]          tcnt_q;
    logic                    done_prev_q;
    logic signed [WIDTH-1:0] eng_d1_q;
    logic signed [WIDTH-1:0] eng_d2_q;
    logic signed [WIDTH-1:0] rsp_nd1_q;
    logic signed [WIDTH-1:0] rsp_nd2_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic                    eng_start_q;
    logic                    eng_reset_q;
    logic                    timeout_err_q;

    logic [NREQ-1:0]         gnt_oh;
    logic [IDW-1:0]          gnt_idx;
    logic                    gnt_any;
    logic [IDW-1:0]          rr_d;
    logic                    done_rise;
    logic                    wait_expired;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (bus.req_valid),
        .rr_i    (rr_q),
        .grant_o (gnt_oh),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign rr_d         = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign done_rise    = bus.eng_done & ~done_prev_q;
    assign wait_expired = (tcnt_q == TCW'(TIMEOUT - 1));

    // Grant is visible combinationally so the lane sees ready in the accept cycle.
    assign bus.req_ready = (state_q == IDLE && !reset) ? gnt_oh : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            rsp_id_q      <= '0;
            icnt_q        <= 1'b0;
            tcnt_q        <= '0;
            done_prev_q   <= 1'b0;
            eng_d1_q      <= '0;
            eng_d2_q      <= '0;
            rsp_nd1_q     <= '0;
            rsp_nd2_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_reset_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_prev_q <= bus.eng_done;
            eng_reset_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        eng_d1_q    <= bus.req_d1[int'(gnt_idx)*WIDTH +: WIDTH];
                        eng_d2_q    <= bus.req_d2[int'(gnt_idx)*WIDTH +: WIDTH];
                        rsp_id_q    <= gnt_idx;
                        rr_q        <= rr_d;
                        rsp_err_q   <= 1'b0;
                        eng_start_q <= 1'b1;
                        icnt_q      <= 1'b0;
                        state_q     <= ISSUE1;
                    end
                end
                // Start is held two cycles: the engine leaves hold, then latches.
                ISSUE1, ISSUE2: begin
                    if (!icnt_q) begin
                        icnt_q <= 1'b1;
                    end else begin
                        eng_start_q <= 1'b0;
                        tcnt_q      <= '0;
                        state_q     <= (state_q == ISSUE1) ? WAIT1 : WAIT2;
                    end
                end
                WAIT1, WAIT2: begin
                    if (done_rise) begin
                        if (state_q == WAIT1) begin
                            rsp_nd1_q   <= bus.eng_nd1;
                            eng_start_q <= 1'b1;
                            icnt_q      <= 1'b0;
                            state_q     <= ISSUE2;
                        end else begin
                            rsp_nd2_q   <= bus.eng_nd2;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else if (wait_expired) begin
                        // Abort the job and resync the engine's d1/d2 phase.
                        timeout_err_q <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_nd1_q     <= '0;
                        rsp_nd2_q     <= '0;
                        eng_reset_q   <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (tcnt_q != {TCW{1'b1}}) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_nd1   = rsp_nd1_q;
    assign bus.rsp_nd2   = rsp_nd2_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_d1    = eng_d1_q;
    assign bus.eng_d2    = eng_d2_q;
    assign bus.eng_reset = eng_reset_q;
    assign busy          = (state_q != IDLE);
    assign timeout_err   = timeout_err_q;

endmodule
